// File: rtl/bexkat2_pkg.sv
// Shared types and widths for the bexkat2 fetch path.
package bexkat2_pkg;

  localparam int INSN_W = 32;
  localparam int IR_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORD0 = 2'd1,
    ST_WORD1 = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  // Queue entry at the default 32-bit address width.
  typedef struct packed {
    logic [31:0]     pc;
    logic [IR_W-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Single-beat Wishbone-style read bus between the fetch unit and instruction memory.
interface ifetch_queue_if import bexkat2_pkg::*; #(
  parameter int AWIDTH = 32
);
  logic              bus_cyc_o;
  logic              bus_stb_o;
  logic [AWIDTH-1:0] bus_adr_o;
  logic              bus_ack_i;
  logic [INSN_W-1:0] bus_dat_i;

  modport master (output bus_cyc_o, bus_stb_o, bus_adr_o, input bus_ack_i, bus_dat_i);
  modport slave  (input bus_cyc_o, bus_stb_o, bus_adr_o, output bus_ack_i, bus_dat_i);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO; flush beats push/pop, read data reads 0 while empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: reads one- or two-word instructions over the bus and
// queues them with their PCs for decode; pc_set redirects and flushes.
module ifetch_queue import bexkat2_pkg::*; #(
  parameter int                DEPTH    = 4,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] RESET_PC = '0,
  parameter int                LONG_BIT = 28
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_set,
  input  logic [AWIDTH-1:0] pc_in,
  input  logic              stall_i,
  output logic [IR_W-1:0]   ir,
  output logic [AWIDTH-1:0] pc,
  output logic              stall_o,
  ifetch_queue_if.master    bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [IR_W-1:0]   ir;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [AWIDTH-1:0] fpc_q, fpc_d;
  logic [AWIDTH-1:0] adr_q, adr_d;
  logic [INSN_W-1:0] word0_q, word0_d;

  entry_t            push_ent, head_ent;
  logic              push, pop_req, cont;
  logic              fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;

  assign pop_req = !fifo_empty && !stall_i;
  // After this push, will there still be room for another fetch?
  assign cont    = (fifo_count - CW'(pop_req)) < CW'(DEPTH - 1);

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    adr_d       = adr_q;
    word0_d     = word0_q;
    push        = 1'b0;
    push_ent.pc = fpc_q;
    push_ent.ir = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_full) begin
          state_d = ST_WORD0;
          adr_d   = fpc_q;
        end
      end
      ST_WORD0: begin
        if (bus.bus_ack_i) begin
          if (bus.bus_dat_i[LONG_BIT]) begin
            word0_d = bus.bus_dat_i;
            adr_d   = fpc_q + AWIDTH'(4);
            state_d = ST_WORD1;
          end else begin
            push        = 1'b1;
            push_ent.ir = {bus.bus_dat_i, 32'h0};
            fpc_d       = fpc_q + AWIDTH'(4);
            adr_d       = fpc_q + AWIDTH'(4);
            state_d     = cont ? ST_WORD0 : ST_IDLE;
          end
        end
      end
      ST_WORD1: begin
        if (bus.bus_ack_i) begin
          push        = 1'b1;
          push_ent.ir = {word0_q, bus.bus_dat_i};
          fpc_d       = fpc_q + AWIDTH'(8);
          adr_d       = fpc_q + AWIDTH'(8);
          state_d     = cont ? ST_WORD0 : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.bus_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect: an unacked cycle must still be drained so its ack isn't taken as new data.
    if (pc_set) begin
      push  = 1'b0;
      fpc_d = pc_in & ~AWIDTH'(3);
      adr_d = adr_q;
      if (state_q != ST_IDLE && !bus.bus_ack_i) state_d = ST_DRAIN;
      else                                      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
      adr_q   <= RESET_PC;
      word0_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      adr_q   <= adr_d;
      word0_q <= word0_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (pc_set),
    .push_i  (push),
    .pop_i   (pop_req && !pc_set),
    .wdata_i (push_ent),
    .rdata_o (head_ent),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.bus_cyc_o = (state_q != ST_IDLE);
  assign bus.bus_stb_o = (state_q != ST_IDLE);
  assign bus.bus_adr_o = adr_q;
  assign ir            = head_ent.ir;
  assign pc            = head_ent.pc;
  assign stall_o       = fifo_empty;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vectors plus random stall/redirect traffic
// checked against an instruction-stream walk over the memory image.
module tb_ifetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0, rst_i = 1'b1, pc_set = 1'b0, stall_i = 1'b0;
  logic [31:0] pc_in = '0;
  logic [63:0] ir;
  logic [31:0] pc;
  logic        stall_o;

  ifetch_queue_if #(.AWIDTH(32)) bus_if ();

  ifetch_queue #(.DEPTH(DEPTH), .AWIDTH(32), .RESET_PC(RPC), .LONG_BIT(28)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_set(pc_set), .pc_in(pc_in), .stall_i(stall_i),
    .ir(ir), .pc(pc), .stall_o(stall_o), .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  // Memory: 256 words, ack after a random wait in [lat_min, lat_max] cycles.
  logic [31:0] mem [256];
  int  lat_min = 0, lat_max = 0, wcnt = 0, acks = 0;
  logic ack = 1'b0;
  assign bus_if.bus_ack_i = ack;
  assign bus_if.bus_dat_i = ack ? mem[bus_if.bus_adr_o[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (ack && bus_if.bus_cyc_o) acks++;
    if (rst_i || !bus_if.bus_cyc_o || ack) begin
      ack  <= 1'b0;
      wcnt <= int'($urandom_range(lat_max, lat_min));
    end else if (wcnt == 0) ack <= 1'b1;
    else wcnt <= wcnt - 1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++; errors++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic reset_hold();
    rst_i = 1'b1; pc_set = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Wait for a valid head (stall_i must be 0), capture it, step past its pop.
  task automatic next_pop(input string name, output logic [31:0] p, output logic [63:0] i);
    int n = 0;
    while (stall_o && n < 100) begin @(negedge clk); n++; end
    if (stall_o) begin timeout(name); p = 'x; i = 'x; end
    else begin p = pc; i = ir; @(negedge clk); end
  endtask

  task automatic wait_cyc(input string name, input logic lvl);
    int n = 0;
    while (bus_if.bus_cyc_o !== lvl && n < 100) begin @(negedge clk); n++; end
    if (bus_if.bus_cyc_o !== lvl) timeout(name);
  endtask

  typedef struct { logic [31:0] pc; logic [63:0] ir; } vec_t;
  vec_t tv [4];

  // Reference: walk the instruction stream defined by the memory image.
  logic [31:0] mpc;
  task automatic model_next(output logic [31:0] ep, output logic [63:0] ei);
    logic [31:0] w, w1, a4;
    a4 = mpc + 32'd4;
    w  = mem[mpc[9:2]];
    w1 = mem[a4[9:2]];
    ep = mpc;
    if (w[28]) begin ei = {w, w1}; mpc = mpc + 32'd8; end
    else       begin ei = {w, 32'h0}; mpc = mpc + 32'd4; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] p;
    logic [63:0] i;
    int t_cyc, t_out, n, pops;
    logic got, stale, after_set, pcyc, pack;
    logic [31:0] cap_adr, padr;

    // ---- 1/2: short and long instructions, table-driven ----
    foreach (mem[k]) mem[k] = 32'h0;
    mem[0] = 32'h0100_0000; mem[1] = 32'h0200_0000; mem[2] = 32'h1000_0005;
    mem[3] = 32'hDEAD_BEEF; mem[4] = 32'h0300_0000;
    tv[0] = '{32'h0,  64'h0100_0000_0000_0000};
    tv[1] = '{32'h4,  64'h0200_0000_0000_0000};
    tv[2] = '{32'h8,  64'h1000_0005_DEAD_BEEF};
    tv[3] = '{32'h10, 64'h0300_0000_0000_0000};
    stall_i = 1'b0;
    reset_hold();
    chk("rst_stall_o", stall_o, 1);
    chk("rst_ir", ir, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cyc", bus_if.bus_cyc_o, 0);
    chk("rst_adr", bus_if.bus_adr_o, RPC);
    rst_i = 1'b0;
    t_cyc = -1; t_out = -1;
    for (int c = 0; c < 20 && t_out < 0; c++) begin
      @(negedge clk);
      if (t_cyc < 0 && bus_if.bus_cyc_o) begin
        t_cyc = c;
        chk("first_adr", bus_if.bus_adr_o, RPC);
        chk("cyc_eq_stb", bus_if.bus_stb_o, 1);
      end
      if (!stall_o) t_out = c;
    end
    chk("first_cyc_cycle", t_cyc, 0);
    chk("short_latency", t_out - t_cyc, 2);
    for (int k = 0; k < 4; k++) begin
      next_pop("vec_pop", p, i);
      chk($sformatf("vec%0d_pc", k), p, tv[k].pc);
      chk($sformatf("vec%0d_ir", k), i, tv[k].ir);
    end

    // ---- long instruction latency from reset ----
    mem[0] = 32'h1000_0001; mem[1] = 32'hCAFE_F00D;
    reset_hold();
    rst_i = 1'b0;
    t_cyc = -1; t_out = -1;
    for (int c = 0; c < 20 && t_out < 0; c++) begin
      @(negedge clk);
      if (t_cyc < 0 && bus_if.bus_cyc_o) t_cyc = c;
      if (!stall_o) t_out = c;
    end
    chk("long_latency", t_out - t_cyc, 4);
    next_pop("long_pop", p, i);
    chk("long_pc", p, 0);
    chk("long_ir", i, 64'h1000_0001_CAFE_F00D);

    // ---- 3: backpressure fills exactly DEPTH entries ----
    for (int k = 0; k < 64; k++) mem[k] = 32'h00A0_0000 + k;
    stall_i = 1'b1;
    reset_hold();
    rst_i = 1'b0;
    acks = 0;
    repeat (40) @(negedge clk);
    chk("full_acks", acks, DEPTH);
    chk("full_cyc_low", bus_if.bus_cyc_o, 0);
    chk("full_head_pc", pc, 0);
    chk("full_head_ir", ir, {32'h00A0_0000, 32'h0});
    stall_i = 1'b0;
    got = 1'b0; cap_adr = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < DEPTH) begin
        chk($sformatf("drain%0d_valid", k), stall_o, 0);
        chk($sformatf("drain%0d_pc", k), pc, 32'(4 * k));
      end
      if (!got && bus_if.bus_cyc_o) begin got = 1'b1; cap_adr = bus_if.bus_adr_o; end
      @(negedge clk);
    end
    chk("resume_adr", cap_adr, 32'h10);

    // ---- 4: redirect during WORD1, late ack drained ----
    mem[0] = 32'h1000_0000; mem[1] = 32'h1111_1111;
    mem[8'h40] = 32'h00B0_0000; mem[8'h41] = 32'h00B0_0001;
    lat_min = 3; lat_max = 3;
    reset_hold();
    rst_i = 1'b0;
    n = 0;
    while (!(bus_if.bus_cyc_o && bus_if.bus_adr_o == 32'h4 && !ack) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) timeout("word1_wait");
    pc_set = 1'b1; pc_in = 32'h103;
    @(negedge clk);
    pc_set = 1'b0;
    chk("drain_cyc", bus_if.bus_cyc_o, 1);
    chk("drain_adr", bus_if.bus_adr_o, 32'h4);
    chk("drain_stall_o", stall_o, 1);
    stale = 1'b0;
    n = 0;
    while (bus_if.bus_cyc_o && n < 100) begin stale |= !stall_o; @(negedge clk); n++; end
    if (n >= 100) timeout("drain_end");
    n = 0;
    while (!bus_if.bus_cyc_o && n < 100) begin stale |= !stall_o; @(negedge clk); n++; end
    if (n >= 100) timeout("redirect_cyc");
    chk("redirect_adr", bus_if.bus_adr_o, 32'h100);
    chk("no_stale_entry", stale, 0);
    next_pop("redirect_pop", p, i);
    chk("redirect_pc", p, 32'h100);
    chk("redirect_ir", i, {32'h00B0_0000, 32'h0});

    // ---- 6: reset with a cycle open ----
    wait_cyc("rst_cyc_wait", 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_cyc", bus_if.bus_cyc_o, 0);
    chk("midrst_stall_o", stall_o, 1);
    chk("midrst_adr", bus_if.bus_adr_o, RPC);

    // ---- 5: random stalls, latency and redirects vs stream model ----
    for (int k = 0; k < 256; k++) begin
      mem[k] = $urandom;
      mem[k][28] = ($urandom_range(0, 2) == 0);
    end
    lat_min = 0; lat_max = 2;
    stall_i = 1'b0;
    reset_hold();
    rst_i = 1'b0;
    mpc = RPC; pops = 0; after_set = 1'b0; pcyc = 1'b0; pack = 1'b0; padr = '0;
    for (int c = 0; c < 3000; c++) begin
      logic ps;
      ps      = ($urandom_range(0, 39) == 0);
      pc_set  = ps;
      pc_in   = 32'($urandom_range(0, 1023));
      stall_i = ($urandom_range(0, 2) == 0);
      chk("rnd_cyc_eq_stb", bus_if.bus_stb_o, bus_if.bus_cyc_o);
      if (pcyc && !pack && bus_if.bus_cyc_o) chk("rnd_adr_stable", bus_if.bus_adr_o, padr);
      if (after_set) chk("rnd_stall_after_set", stall_o, 1);
      after_set = 1'b0;
      if (ps) begin
        mpc = pc_in & ~32'h3;
        after_set = 1'b1;
      end else if (!stall_o && !stall_i) begin
        logic [31:0] ep;
        logic [63:0] ei;
        model_next(ep, ei);
        chk("rnd_pc", pc, ep);
        chk("rnd_ir", ir, ei);
        pops++;
      end
      pcyc = bus_if.bus_cyc_o; pack = ack; padr = bus_if.bus_adr_o;
      @(negedge clk);
    end
    pc_set = 1'b0;
    chk("rnd_enough_pops", (pops > 3 * DEPTH), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch unit with a prefetch queue, succeeding the single-entry fetch stage that feeds `idecode` in the bexkat2 pipeline. It issues single-beat Wishbone-style reads to instruction memory and assembles one- or two-word instructions into 64-bit `ir` values. It buffers up to `DEPTH` decoded-width instructions with their PCs and presents them to decode under a stall handshake. A `pc_set` redirect flushes the queue and any in-flight assembly.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `AWIDTH`, 32: byte-address width of `pc` and `bus_adr_o`.
- `RESET_PC`, 0: fetch address after reset; word aligned.
- `LONG_BIT`, 28: bit of the first instruction word that marks a two-word instruction.

Ports:
- `clk_i`  in  1  clock; everything rising-edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `pc_set`  in  1  redirect strobe.
- `pc_in`  in  AWIDTH  redirect target; bits [1:0] ignored, treated as 0.
- `stall_i`  in  1  downstream cannot accept; hold head entry.
- `ir`  out  64  head instruction: [63:32] first word, [31:0] extension word or 0.
- `pc`  out  AWIDTH  byte address of the head instruction's first word.
- `stall_o`  out  1  1 = no valid instruction at output (queue empty).
- `bus_cyc_o`, `bus_stb_o`  out  1  bus cycle / strobe, always driven equal.
- `bus_adr_o`  out  AWIDTH  word-aligned byte address.
- `bus_ack_i`  in  1  read acknowledge.
- `bus_dat_i`  in  32  read data, valid with `bus_ack_i`.

## Operation
- FSM states: IDLE, WORD0, WORD1, DRAIN.
  - IDLE: if `count < DEPTH`, assert cyc at `fpc` and go to WORD0.
  - WORD0, on ack: latch the word.
    - Word bit `LONG_BIT` = 1: `bus_adr_o ← fpc+4`, go to WORD1.
    - Otherwise push `{word, 32'h0}` with `pc = fpc`, set `fpc += 4`, and go to WORD0 if `count_next < DEPTH`, else IDLE (cyc low).
  - WORD1, on ack: push `{word0, word}` with `pc = fpc`, set `fpc += 8`, same continuation rule.
  - DRAIN: hold cyc until ack, discard data, then go to IDLE.
- `bus_adr_o` and cyc are stable while waiting for ack. A new cycle may start on the edge after an ack.
- Queue: circular buffer with read/write pointers and a `$clog2(DEPTH)+1`-bit count.
  - Pop when `!stall_o && !stall_i`.
  - Push and pop in the same cycle leave count unchanged.
  - A fetch starts only when `count < DEPTH`, so a push never overflows: only one instruction assembles at a time, and count cannot rise meanwhile.
  - Pointers wrap modulo DEPTH.
- `pc_set` has priority over everything:
  - Queue cleared (count 0, pointers 0); any partial word0 discarded; `fpc ← pc_in`.
  - Any same-cycle push or pop is suppressed.
  - If a bus cycle is outstanding and not acked that cycle, go to DRAIN; else IDLE.
  - A `pc_set` in DRAIN only updates `fpc`.
- Address arithmetic wraps modulo 2^AWIDTH.

## Timing
- Reset values:
  - `stall_o` 1; `ir` 0; `pc` 0.
  - `bus_cyc_o`/`bus_stb_o` 0; `bus_adr_o` = `RESET_PC`.
  - FSM IDLE; `fpc` = `RESET_PC`; queue empty.
- First cyc is asserted the cycle after `rst_i` deasserts.
- `ir`/`pc`/`stall_o` come from registered queue state. An instruction pushed at edge N is visible after edge N, so `stall_o` falls in cycle N+1.
- With a 1-cycle-ack memory, a short instruction reaches the output 2 cycles after its cyc rises, and a long instruction 4 cycles after.
- After `pc_set` at edge N, `stall_o` is 1 from cycle N+1 until the first instruction from `pc_in` is pushed.
- A reset mid-cycle drops cyc immediately; no drain.

## Structure
- Shared package `bexkat2_pkg`:
  - `fetch_state_t` enum.
  - `INSN_W = 32`, `IR_W = 64`.
  - Entry struct `{pc, ir}`.
- Natural sub-module `fetch_fifo`: parametrised synchronous circular FIFO with `DEPTH`, `WIDTH`, push, pop, flush, count, empty and full.
- The FSM and assembly logic live in `ifetch_queue`.

## Test plan
1. Reset, then memory 0x0: 0x01000000, 0x4: 0x02000000, with `stall_i=0` and 1-cycle-ack RAM → `pc` 0x0 then 0x4; `ir` = 0x0100000000000000 then 0x0200000000000000; `stall_o` falls 2 cycles after first cyc.
2. Word 0x10000005 (bit 28 set) at 0x8, followed by 0xDEADBEEF → a single entry with `ir`=0x10000005DEADBEEF and `pc`=0x8; the next fetch is at 0x10.
3. Hold `stall_i=1` with DEPTH=4 → exactly 4 entries queued, cyc falls; the head stays at `pc` 0x0. Release `stall_i` → entries pop one per cycle and fetch resumes at 0x10.
4. Assert `pc_set` with `pc_in`=0x103 while in WORD1, ack not yet given → DRAIN, the late ack is discarded, and the next cyc has `bus_adr_o`=0x100. No stale entry appears; the first output is `pc`=0x100.
5. Push and pop in the same cycle with `count==DEPTH-1` → count is unchanged and no fetch stall. Pointer wrap is exercised across 3×DEPTH instructions with in-order PCs.
6. Assert `rst_i` while cyc is high → next cycle cyc=0, `stall_o`=1, `bus_adr_o`=`RESET_PC`.
